// File: rtl/riscv_regfile_mp_if.sv
// Bus bundle for riscv_regfile_mp: read ports, write ports, reserve port, scoreboard.
// master: decode/writeback side that drives addresses and data.
// slave : the register file.
// Signals:
//   raddr_i NRD*AW, rdata_o NRD*XLEN, rbusy_o NRD  - read ports
//   we_i NWR, waddr_i NWR*AW, wdata_i NWR*XLEN     - write ports
//   rsv_i, rsv_addr_i AW                           - reserve request
//   busy_vec_o NREG                                - full scoreboard
interface riscv_regfile_mp_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 1
);
    localparam int unsigned AW = $clog2(NREG);

    logic [NRD*AW-1:0]   raddr_i;
    logic [NRD*XLEN-1:0] rdata_o;
    logic [NRD-1:0]      rbusy_o;
    logic [NWR-1:0]      we_i;
    logic [NWR*AW-1:0]   waddr_i;
    logic [NWR*XLEN-1:0] wdata_i;
    logic                rsv_i;
    logic [AW-1:0]       rsv_addr_i;
    logic [NREG-1:0]     busy_vec_o;

    modport master (
        output raddr_i, we_i, waddr_i, wdata_i, rsv_i, rsv_addr_i,
        input  rdata_o, rbusy_o, busy_vec_o
    );

    modport slave (
        input  raddr_i, we_i, waddr_i, wdata_i, rsv_i, rsv_addr_i,
        output rdata_o, rbusy_o, busy_vec_o
    );
endinterface

// File: rtl/riscv_regfile_mp.sv
// Multi-port integer register file with hardwired-zero x0 and a busy scoreboard.
// NRD combinational read ports, NWR synchronous write ports (higher port wins on
// collision), one reserve port that marks a destination busy until it is written.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
// Ports:
//   clk_i  - clock, all state updates on the rising edge
//   rst_i  - synchronous active-high reset (clears registers and scoreboard)
//   rf     - riscv_regfile_mp_if.slave bundle (read/write/reserve/scoreboard)
module riscv_regfile_mp #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    riscv_regfile_mp_if.slave rf
);
    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next state: writes in port order so port 1 overrides port 0; reserve set after
    // write release so a same-cycle reserve leaves the register busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (rf.we_i[j]) begin
                regs_d[rf.waddr_i[j*AW +: AW]] = rf.wdata_i[j*XLEN +: XLEN];
                busy_d[rf.waddr_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (rf.rsv_i) begin
            busy_d[rf.rsv_addr_i] = 1'b1;
        end
        // x0 is never stored and never busy
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports; busy flag always comes from the registered scoreboard
    always_comb begin
        rf.rdata_o = '0;
        rf.rbusy_o = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            rf.rbusy_o[k] = busy_q[rf.raddr_i[k*AW +: AW]];
            if (rf.raddr_i[k*AW +: AW] != '0) begin
                rf.rdata_o[k*XLEN +: XLEN] = regs_q[rf.raddr_i[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                // Later write port overrides earlier one, matching collision priority
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (!rst_i && rf.we_i[j] &&
                        (rf.waddr_i[j*AW +: AW] == rf.raddr_i[k*AW +: AW])) begin
                        rf.rdata_o[k*XLEN +: XLEN] = rf.wdata_i[j*XLEN +: XLEN];
                    end
                end
`endif
            end
        end
    end

    assign rf.busy_vec_o = busy_q;
endmodule
